// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus shared by NREQ requesters in front of the register-file write port.
// Handshake: a transfer happens on a rising edge where req_valid[i] && req_ready[i]; a requester
// holds req_valid/req_wsel/req_wdat stable until that edge, and req_ready never depends on req_wdat.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][4:0]    req_wsel;
  logic [NREQ-1:0][DW-1:0] req_wdat;
  logic [NREQ-1:0]         req_ready;

  modport master (
    output req_valid,
    output req_wsel,
    output req_wdat,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_wsel,
    input  req_wdat,
    output req_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port with a destination-register
// reservation scoreboard and a sticky flag for writes that hit an unreserved register.
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_wsel,
  regfile_wb_arbiter_if.slave   wb,
  output logic                  WEN,
  output logic [4:0]            wsel,
  output logic [DW-1:0]         wdat,
  output logic [31:0]           busy,
  output logic                  stray_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            wen_q, wen_d;
  logic [4:0]      wsel_q, wsel_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [31:0]     busy_q, busy_d;
  logic            stray_q, stray_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cand_idx;
  logic            xfer;
  logic [4:0]      xfer_sel;
  logic [DW-1:0]   xfer_dat;
  logic            issue_set;
  int              cand;

  // Scan from the pointer upward, wrapping; first valid requester wins.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    cand_idx = '0;
    cand     = 0;
    xfer     = 1'b0;
    if (!RST && !flush) begin
      for (int off = 0; off < NREQ; off++) begin
        cand     = (int'(ptr_q) + off) % NREQ;
        cand_idx = PW'(cand);
        if (!xfer && wb.req_valid[cand_idx]) begin
          xfer            = 1'b1;
          grant[cand_idx] = 1'b1;
          gnt_idx         = cand_idx;
        end
      end
    end
  end

  assign wb.req_ready = grant;
  assign xfer_sel     = wb.req_wsel[gnt_idx];
  assign xfer_dat     = wb.req_wdat[gnt_idx];
  assign issue_set    = issue_valid && (issue_wsel != 5'd0);

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Writes to r0 are accepted but never reach the register file; outputs hold otherwise.
  always_comb begin
    wen_d  = 1'b0;
    wsel_d = wsel_q;
    wdat_d = wdat_q;
    if (xfer && (xfer_sel != 5'd0)) begin
      wen_d  = 1'b1;
      wsel_d = xfer_sel;
      wdat_d = xfer_dat;
    end
  end

  // Clear first, then set, so a same-cycle reservation of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (xfer && (xfer_sel != 5'd0)) begin
        busy_d[xfer_sel] = 1'b0;
      end
      if (issue_set) begin
        busy_d[issue_wsel] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    stray_d = stray_q;
    if (xfer && (xfer_sel != 5'd0) && !busy_q[xfer_sel] &&
        !(issue_set && (issue_wsel == xfer_sel))) begin
      stray_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q   <= '0;
      wen_q   <= 1'b0;
      wsel_q  <= '0;
      wdat_q  <= '0;
      busy_q  <= '0;
      stray_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      wsel_q  <= wsel_d;
      wdat_q  <= wdat_d;
      busy_q  <= busy_d;
      stray_q <= stray_d;
    end
  end

  assign WEN       = wen_q;
  assign wsel      = wsel_q;
  assign wdat      = wdat_q;
  assign busy      = busy_q;
  assign stray_err = stray_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reservation scoreboard, round-robin grants,
// r0 writes, stray writes, flush and reset priority, all with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_wsel;
  logic        wen;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [31:0] busy;
  logic        stray_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [4:0] exp_q[$];

  regfile_wb_arbiter_if #(.NREQ(2), .DW(32)) bus ();

  regfile_wb_arbiter #(.NREQ(2), .DW(32)) dut (
    .CLK         (clk),
    .RST         (rst),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_wsel  (issue_wsel),
    .wb          (bus),
    .WEN         (wen),
    .wsel        (wsel),
    .wdat        (wdat),
    .busy        (busy),
    .stray_err   (stray_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int idx, input logic v, input logic [4:0] s, input logic [31:0] d);
    bus.req_valid[idx] = v;
    bus.req_wsel[idx]  = s;
    bus.req_wdat[idx]  = d;
  endtask

  task automatic idle_reqs();
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_reqs();
    flush       = 1'b0;
    issue_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] k);
    issue_valid = 1'b1;
    issue_wsel  = k;
    step();
    issue_valid = 1'b0;
  endtask

  // Checker
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_wsel  = '0;
    bus.req_valid = '0;
    bus.req_wsel  = '0;
    bus.req_wdat  = '0;

    // Reset state, and no grants while reset is held
    step();
    drive_req(0, 1'b1, 5'd3, 32'h1);
    drive_req(1, 1'b1, 5'd4, 32'h2);
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'h0);
    step();
    idle_reqs();
    rst = 1'b0;
    #1;
    check("rst_wen", 64'(wen), 64'h0);
    check("rst_wsel", 64'(wsel), 64'h0);
    check("rst_wdat", 64'(wdat), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_stray", 64'(stray_err), 64'h0);

    // Reserve r5, then write it back from requester 0
    issue(5'd5);
    check("t1_busy_set", 64'(busy), 64'h20);
    drive_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("t1_ready", 64'(bus.req_ready), 64'h1);
    step();
    idle_reqs();
    check("t1_wen", 64'(wen), 64'h1);
    check("t1_wsel", 64'(wsel), 64'h5);
    check("t1_wdat", 64'(wdat), 64'hDEADBEEF);
    check("t1_busy_clr", 64'(busy), 64'h0);
    check("t1_stray", 64'(stray_err), 64'h0);
    step();
    check("t1_wen_off", 64'(wen), 64'h0);
    check("t1_wsel_hold", 64'(wsel), 64'h5);
    check("t1_wdat_hold", 64'(wdat), 64'hDEADBEEF);

    // Round-robin with both requesters continuously valid
    do_reset();
    drive_req(0, 1'b1, 5'd3, 32'h33);
    drive_req(1, 1'b1, 5'd4, 32'h44);
    exp_q.push_back(5'd3);
    exp_q.push_back(5'd4);
    exp_q.push_back(5'd3);
    exp_q.push_back(5'd4);
    for (int i = 0; i < 4; i++) begin
      logic [4:0] exp_sel;
      #1;
      exp_sel = exp_q.pop_front();
      check("t2_ready", 64'(bus.req_ready), (exp_sel == 5'd3) ? 64'h1 : 64'h2);
      step();
      check("t2_wen", 64'(wen), 64'h1);
      check("t2_wsel", 64'(wsel), 64'(exp_sel));
    end
    idle_reqs();

    // Same-cycle re-reservation and write of r7 leaves it busy
    do_reset();
    issue(5'd7);
    check("t3_busy", 64'(busy), 64'h80);
    issue_valid = 1'b1;
    issue_wsel  = 5'd7;
    drive_req(0, 1'b1, 5'd7, 32'h77);
    #1;
    check("t3_ready", 64'(bus.req_ready), 64'h1);
    step();
    issue_valid = 1'b0;
    idle_reqs();
    check("t3_busy_kept", 64'(busy), 64'h80);
    check("t3_stray", 64'(stray_err), 64'h0);
    check("t3_wen", 64'(wen), 64'h1);

    // Stray write to r9 from requester 1; flag is sticky
    do_reset();
    drive_req(1, 1'b1, 5'd9, 32'h99);
    #1;
    check("t4_ready", 64'(bus.req_ready), 64'h2);
    step();
    idle_reqs();
    check("t4_wen", 64'(wen), 64'h1);
    check("t4_wsel", 64'(wsel), 64'h9);
    check("t4_stray", 64'(stray_err), 64'h1);
    for (int i = 0; i < 10; i++) step();
    check("t4_stray_hold", 64'(stray_err), 64'h1);
    check("t4_wen_idle", 64'(wen), 64'h0);

    // r0 write is accepted but suppressed; then flush with both valid
    do_reset();
    issue(5'd1);
    issue(5'd2);
    issue(5'd3);
    issue(5'd8);
    issue(5'd9);
    issue(5'd10);
    issue(5'd11);
    check("t5_busy", 64'(busy), 64'h0F0E);
    drive_req(0, 1'b1, 5'd0, 32'h1234);
    #1;
    check("t6_ready", 64'(bus.req_ready), 64'h1);
    step();
    idle_reqs();
    check("t6_wen", 64'(wen), 64'h0);
    check("t6_busy", 64'(busy), 64'h0F0E);
    check("t6_wdat_hold", 64'(wdat), 64'h0);
    drive_req(0, 1'b1, 5'd1, 32'hAA);
    drive_req(1, 1'b1, 5'd2, 32'hBB);
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_wsel  = 5'd12;
    #1;
    check("t5_flush_ready", 64'(bus.req_ready), 64'h0);
    step();
    flush       = 1'b0;
    issue_valid = 1'b0;
    check("t5_busy_flushed", 64'(busy), 64'h0);
    check("t5_stray", 64'(stray_err), 64'h0);
    #1;
    check("t5_ptr_kept", 64'(bus.req_ready), 64'h2);
    step();
    check("t5_wen", 64'(wen), 64'h1);
    check("t5_wsel", 64'(wsel), 64'h2);
    check("t5_wdat", 64'(wdat), 64'hBB);
    flush = 1'b1;
    #1;
    check("t5_flush_ready2", 64'(bus.req_ready), 64'h0);
    step();
    flush = 1'b0;
    idle_reqs();
    check("t5_wen_flushed", 64'(wen), 64'h0);

    // Reset wins over a pending write
    drive_req(0, 1'b1, 5'd6, 32'h66);
    #1;
    check("t7_ready", 64'(bus.req_ready), 64'h1);
    step();
    idle_reqs();
    check("t7_wen", 64'(wen), 64'h1);
    rst = 1'b1;
    drive_req(0, 1'b1, 5'd6, 32'h67);
    #1;
    check("t7_rst_ready", 64'(bus.req_ready), 64'h0);
    step();
    rst = 1'b0;
    idle_reqs();
    check("t7_rst_wen", 64'(wen), 64'h0);
    check("t7_rst_wdat", 64'(wdat), 64'h0);

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, number of writeback requesters sharing the register-file write port.
REQ-002 The block SHALL have parameter DW, default 32, write-data width in bits.
REQ-003 Port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Port RST  input  1  reset, synchronous and active-high.
REQ-005 Port flush  input  1  discard all reservations; suppress grants this cycle.
REQ-006 Port issue_valid  input  1  destination reservation strobe from issue stage.
REQ-007 Port issue_wsel  input  5  destination register being reserved.
REQ-008 Port req_valid  input  NREQ  per-requester write request.
REQ-009 Port req_wsel  input  NREQ x 5  per-requester destination register.
REQ-010 Port req_wdat  input  NREQ x DW  per-requester write data.
REQ-011 Port req_ready  output  NREQ  per-requester grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-012 Port WEN  output  1  register-file write enable.
REQ-013 Port wsel  output  5  register-file write select.
REQ-014 Port wdat  output  DW  register-file write data.
REQ-015 Port busy  output  32  scoreboard; bit k high = write to register k outstanding.
REQ-016 Port stray_err  output  1  sticky flag: write accepted to a non-busy register.

Function
REQ-017 req_ready SHALL be combinational from req_valid, flush and the round-robin pointer; at most one bit high per cycle; no bit high unless its req_valid is high.
REQ-018 Arbitration SHALL be round-robin: highest priority goes to the requester index following the last granted index (modulo NREQ); after reset requester 0 has highest priority.
REQ-019 The pointer SHALL update only on a cycle with a transfer; idle cycles leave it unchanged.
REQ-020 Requesters SHALL hold req_valid, req_wsel, req_wdat stable until transfer; the block never drops an unaccepted request.
REQ-021 A transfer in cycle N SHALL drive WEN=1, wsel=req_wsel[i], wdat=req_wdat[i] registered for exactly cycle N+1; WEN=0 in cycles with no preceding transfer.
REQ-022 A transfer with req_wsel=0 SHALL be accepted and advance the pointer but produce WEN=0 in cycle N+1.
REQ-023 wsel and wdat SHALL hold their last values while WEN=0.
REQ-024 issue_valid with issue_wsel=k, k!=0, SHALL set busy[k] on the next edge; issue_wsel=0 SHALL have no effect.
REQ-025 A transfer with req_wsel=k, k!=0, SHALL clear busy[k] on the next edge.
REQ-026 Simultaneous set and clear of the same busy bit SHALL leave it set (new reservation wins).
REQ-027 busy[0] SHALL be constant 0.
REQ-028 A transfer with req_wsel=k, k!=0, while busy[k]=0 and no same-cycle set of k SHALL set stray_err on the next edge; stray_err stays high until RST.
REQ-029 flush=1 SHALL force req_ready=0, clear all busy bits on the next edge, ignore issue_valid that cycle; a write already registered for the following cycle SHALL still complete.
REQ-030 flush SHALL NOT alter the round-robin pointer or stray_err.

Reset
REQ-031 RST=1 at a rising edge SHALL set WEN=0, wsel=0, wdat=0, busy=0, stray_err=0, pointer to favour requester 0.
REQ-032 While RST=1, req_ready SHALL be 0 for all requesters.
REQ-033 RST asserted in the cycle after a transfer SHALL take priority: WEN=0 in the following cycle, write lost.

Verification
REQ-034 Reset, then issue_valid wsel=5, then req_valid=01 wsel=5 wdat=0xDEADBEEF -> busy[5]=1 one cycle after issue; req_ready=01; next cycle WEN=1 wsel=5 wdat=0xDEADBEEF; busy[5]=0 after.
REQ-035 Both requesters valid continuously for 4 cycles after reset, wsel 3/4 -> grants 01,10,01,10; WEN=1 on 4 consecutive cycles with wsel 3,4,3,4.
REQ-036 busy[7]=1; same cycle issue wsel=7 and transfer wsel=7 -> busy[7] remains 1; stray_err stays 0.
REQ-037 Transfer wsel=9 with busy[9]=0 -> WEN=1 wsel=9 next cycle; stray_err=1 and held through 10 idle cycles.
REQ-038 busy=0x0000_0F0E, req_valid=11, flush=1 -> req_ready=00 that cycle; busy=0 next cycle; pointer unchanged (next grant goes to the previously favoured requester).
REQ-039 Transfer wsel=0 wdat=0x1234 -> req_ready high, next cycle WEN=0, busy unchanged.
